// File: rtl/taxi_mac_ctrl_rx_if.sv
// AXI-Stream bundle used on both the sink and source side of taxi_mac_ctrl_rx.
// The master drives everything except tready; the slave drives tready.
interface taxi_mac_ctrl_rx_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_mac_ctrl_rx.sv
// Receive-side MAC control frame extractor: one-stage AXI-Stream pass-through that
// decodes the header/opcode/params of each frame. Optional PFC opcode: TAXI_MAC_CTRL_RX_PFC_EN.
module taxi_mac_ctrl_rx #(
  parameter int DATA_W          = 64,
  parameter int ID_W            = 8,
  parameter int DEST_W          = 8,
  parameter int USER_W          = 1,
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  taxi_mac_ctrl_rx_if.slave            s_axis,
  taxi_mac_ctrl_rx_if.master           m_axis,
  output logic                         mcf_valid,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,
  output logic [ID_W-1:0]              mcf_id,
  output logic [DEST_W-1:0]            mcf_dest,
  output logic [USER_W-1:0]            mcf_user,
  input  logic [47:0]                  cfg_mcf_rx_eth_dst_mcast,
  input  logic                         cfg_mcf_rx_check_eth_dst_mcast,
  input  logic [47:0]                  cfg_mcf_rx_eth_dst_ucast,
  input  logic                         cfg_mcf_rx_check_eth_dst_ucast,
  input  logic [47:0]                  cfg_mcf_rx_eth_src,
  input  logic                         cfg_mcf_rx_check_eth_src,
  input  logic [15:0]                  cfg_mcf_rx_eth_type,
  input  logic [15:0]                  cfg_mcf_rx_opcode_lfc,
  input  logic                         cfg_mcf_rx_check_opcode_lfc,
`ifdef TAXI_MAC_CTRL_RX_PFC_EN
  input  logic [15:0]                  cfg_mcf_rx_opcode_pfc,
  input  logic                         cfg_mcf_rx_check_opcode_pfc,
`endif
  input  logic                         cfg_mcf_rx_forward,
  input  logic                         cfg_mcf_rx_enable,
  output logic                         stat_rx_mcf
);

  localparam int KEEP_W  = DATA_W / 8;
  localparam int HDR_LEN = 16 + MCF_PARAMS_SIZE;
  localparam int PTR_W   = $clog2(HDR_LEN + 1);

  logic [7:0]                   hdr_q   [HDR_LEN];
  logic [7:0]                   hdr_cur [HDR_LEN];
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic                         len_ok;
  logic [47:0]                  dst_c, src_c;
  logic [15:0]                  type_c, op_c;
  logic [MCF_PARAMS_SIZE*8-1:0] par_c;
  logic                         dst_ok, src_ok, op_ok, detect_c, mark_c, s_accept;
  logic [USER_W-1:0]            user_out_c;

  logic                         m_tvalid_q;
  logic [DATA_W-1:0]            m_tdata_q;
  logic [KEEP_W-1:0]            m_tkeep_q;
  logic                         m_tlast_q;
  logic [ID_W-1:0]              m_tid_q;
  logic [DEST_W-1:0]            m_tdest_q;
  logic [USER_W-1:0]            m_tuser_q;
  logic                         mcf_valid_q;

  assign s_axis.tready = rst & (m_axis.tready | ~m_tvalid_q);
  assign s_accept      = s_axis.tvalid & s_axis.tready;

  // Header bytes as they stand once the current beat is merged in; tkeep is
  // assumed packed from lane 0, so lane i lands at offset ptr_q + i.
  always_comb begin
    int cnt;
    hdr_cur = hdr_q;
    cnt     = 0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (s_axis.tkeep[i]) cnt = cnt + 1;
      for (int j = 0; j < HDR_LEN; j++) begin
        if (s_axis.tkeep[i] && (int'(ptr_q) + i == j)) hdr_cur[j] = s_axis.tdata[8*i +: 8];
      end
    end
    len_ok = (int'(ptr_q) + cnt) >= 16;
    ptr_d  = ((int'(ptr_q) + cnt) >= HDR_LEN) ? PTR_W'(HDR_LEN) : PTR_W'(int'(ptr_q) + cnt);
  end

  always_comb begin
    dst_c  = '0;
    src_c  = '0;
    par_c  = '0;
    for (int k = 0; k < 6; k++) begin
      dst_c[47-8*k -: 8] = hdr_cur[k];
      src_c[47-8*k -: 8] = hdr_cur[6+k];
    end
    type_c = {hdr_cur[12], hdr_cur[13]};
    op_c   = {hdr_cur[14], hdr_cur[15]};
    for (int j = 0; j < MCF_PARAMS_SIZE; j++) par_c[8*j +: 8] = hdr_cur[16+j];
  end

  always_comb begin
    dst_ok = (cfg_mcf_rx_check_eth_dst_mcast && (dst_c == cfg_mcf_rx_eth_dst_mcast)) ||
             (cfg_mcf_rx_check_eth_dst_ucast && (dst_c == cfg_mcf_rx_eth_dst_ucast)) ||
             (!cfg_mcf_rx_check_eth_dst_mcast && !cfg_mcf_rx_check_eth_dst_ucast);
    src_ok = !cfg_mcf_rx_check_eth_src || (src_c == cfg_mcf_rx_eth_src);
`ifdef TAXI_MAC_CTRL_RX_PFC_EN
    op_ok  = (cfg_mcf_rx_check_opcode_lfc && (op_c == cfg_mcf_rx_opcode_lfc)) ||
             (cfg_mcf_rx_check_opcode_pfc && (op_c == cfg_mcf_rx_opcode_pfc)) ||
             (!cfg_mcf_rx_check_opcode_lfc && !cfg_mcf_rx_check_opcode_pfc);
`else
    op_ok  = (cfg_mcf_rx_check_opcode_lfc && (op_c == cfg_mcf_rx_opcode_lfc)) ||
             !cfg_mcf_rx_check_opcode_lfc;
`endif
    detect_c   = cfg_mcf_rx_enable && len_ok && (type_c == cfg_mcf_rx_eth_type) &&
                 dst_ok && src_ok && op_ok && !s_axis.tuser[0];
    mark_c     = s_axis.tlast && detect_c && !cfg_mcf_rx_forward;
    user_out_c = s_axis.tuser | USER_W'(mark_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tkeep_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_tid_q      <= '0;
      m_tdest_q    <= '0;
      m_tuser_q    <= '0;
      mcf_valid_q  <= 1'b0;
      mcf_eth_dst  <= '0;
      mcf_eth_src  <= '0;
      mcf_eth_type <= '0;
      mcf_opcode   <= '0;
      mcf_params   <= '0;
      mcf_id       <= '0;
      mcf_dest     <= '0;
      mcf_user     <= '0;
      ptr_q        <= '0;
      for (int j = 0; j < HDR_LEN; j++) hdr_q[j] <= '0;
    end else begin
      mcf_valid_q <= 1'b0;
      if (m_axis.tready) m_tvalid_q <= 1'b0;
      if (s_accept) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis.tdata;
        m_tkeep_q  <= s_axis.tkeep;
        m_tlast_q  <= s_axis.tlast;
        m_tid_q    <= s_axis.tid;
        m_tdest_q  <= s_axis.tdest;
        m_tuser_q  <= user_out_c;
        if (s_axis.tlast) begin
          // Zeroed header doubles as "unreceived param bytes read as 0" for the next frame.
          ptr_q <= '0;
          for (int j = 0; j < HDR_LEN; j++) hdr_q[j] <= '0;
          if (detect_c) begin
            mcf_valid_q  <= 1'b1;
            mcf_eth_dst  <= dst_c;
            mcf_eth_src  <= src_c;
            mcf_eth_type <= type_c;
            mcf_opcode   <= op_c;
            mcf_params   <= par_c;
            mcf_id       <= s_axis.tid;
            mcf_dest     <= s_axis.tdest;
            mcf_user     <= s_axis.tuser;
          end
        end else begin
          ptr_q <= ptr_d;
          hdr_q <= hdr_cur;
        end
      end
    end
  end

  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tid    = m_tid_q;
  assign m_axis.tdest  = m_tdest_q;
  assign m_axis.tuser  = m_tuser_q;
  assign mcf_valid     = mcf_valid_q;
  assign stat_rx_mcf   = mcf_valid_q;

endmodule

// File: tb/tb_taxi_mac_ctrl_rx.sv
// Directed bench for taxi_mac_ctrl_rx: a 64-bit and an 8-bit instance share config;
// per-instance monitors collect output bytes/pulses, tasks compare against expected queues.
`timescale 1ns/1ps
module tb_taxi_mac_ctrl_rx;
  typedef logic [7:0] frame_t [128];

  localparam logic [47:0] MCAST = 48'h0180C2000001;
  localparam logic [47:0] UCAST = 48'h02AABBCCDDEE;
  localparam logic [47:0] SRC   = 48'h5A5152535455;

  int checks = 0;
  int errors = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] cfg_mcast, cfg_ucast, cfg_src;
  logic        cfg_chk_mcast, cfg_chk_ucast, cfg_chk_src;
  logic [15:0] cfg_type, cfg_lfc;
  logic        cfg_chk_lfc, cfg_forward, cfg_enable;

  taxi_mac_ctrl_rx_if #(.DATA_W(64)) s64 ();
  taxi_mac_ctrl_rx_if #(.DATA_W(64)) m64 ();
  taxi_mac_ctrl_rx_if #(.DATA_W(8))  s8 ();
  taxi_mac_ctrl_rx_if #(.DATA_W(8))  m8 ();

  logic         mcf_valid64, stat64, mcf_valid8, stat8;
  logic [47:0]  dst64, src64, dst8, src8;
  logic [15:0]  type64, op64, type8, op8;
  logic [143:0] par64, par8;
  logic [7:0]   id64, dest64, id8, dest8;
  logic [0:0]   user64, user8;

  taxi_mac_ctrl_rx #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .s_axis(s64), .m_axis(m64),
    .mcf_valid(mcf_valid64), .mcf_eth_dst(dst64), .mcf_eth_src(src64), .mcf_eth_type(type64),
    .mcf_opcode(op64), .mcf_params(par64), .mcf_id(id64), .mcf_dest(dest64), .mcf_user(user64),
    .cfg_mcf_rx_eth_dst_mcast(cfg_mcast), .cfg_mcf_rx_check_eth_dst_mcast(cfg_chk_mcast),
    .cfg_mcf_rx_eth_dst_ucast(cfg_ucast), .cfg_mcf_rx_check_eth_dst_ucast(cfg_chk_ucast),
    .cfg_mcf_rx_eth_src(cfg_src), .cfg_mcf_rx_check_eth_src(cfg_chk_src),
    .cfg_mcf_rx_eth_type(cfg_type), .cfg_mcf_rx_opcode_lfc(cfg_lfc),
    .cfg_mcf_rx_check_opcode_lfc(cfg_chk_lfc), .cfg_mcf_rx_forward(cfg_forward),
    .cfg_mcf_rx_enable(cfg_enable), .stat_rx_mcf(stat64)
  );

  taxi_mac_ctrl_rx #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .s_axis(s8), .m_axis(m8),
    .mcf_valid(mcf_valid8), .mcf_eth_dst(dst8), .mcf_eth_src(src8), .mcf_eth_type(type8),
    .mcf_opcode(op8), .mcf_params(par8), .mcf_id(id8), .mcf_dest(dest8), .mcf_user(user8),
    .cfg_mcf_rx_eth_dst_mcast(cfg_mcast), .cfg_mcf_rx_check_eth_dst_mcast(cfg_chk_mcast),
    .cfg_mcf_rx_eth_dst_ucast(cfg_ucast), .cfg_mcf_rx_check_eth_dst_ucast(cfg_chk_ucast),
    .cfg_mcf_rx_eth_src(cfg_src), .cfg_mcf_rx_check_eth_src(cfg_chk_src),
    .cfg_mcf_rx_eth_type(cfg_type), .cfg_mcf_rx_opcode_lfc(cfg_lfc),
    .cfg_mcf_rx_check_opcode_lfc(cfg_chk_lfc), .cfg_mcf_rx_forward(cfg_forward),
    .cfg_mcf_rx_enable(cfg_enable), .stat_rx_mcf(stat8)
  );

  // scoreboard state
  logic [7:0] exp64_q[$], got64_q[$], exp8_q[$], got8_q[$];
  logic       expu64_q[$], gotu64_q[$], expu8_q[$], gotu8_q[$];
  int         pulse64 = 0, pulse8 = 0, misalign = 0, stat_err = 0;
  logic [15:0]  cap_op64, cap_type64, cap_op8, cap_type8;
  logic [47:0]  cap_dst64, cap_src64, cap_dst8;
  logic [143:0] cap_par64;
  logic [7:0]   cap_id64, cap_dest64, last_id64, last_dest64;
  logic         cap_user64;

  always @(negedge clk) begin
    if (m64.tvalid && m64.tready) begin
      for (int i = 0; i < 8; i++) if (m64.tkeep[i]) got64_q.push_back(m64.tdata[8*i +: 8]);
      if (m64.tlast) begin
        gotu64_q.push_back(m64.tuser[0]);
        last_id64   = m64.tid;
        last_dest64 = m64.tdest;
      end
    end
    if (mcf_valid64) begin
      pulse64++;
      cap_op64 = op64; cap_type64 = type64; cap_dst64 = dst64; cap_src64 = src64;
      cap_par64 = par64; cap_id64 = id64; cap_dest64 = dest64; cap_user64 = user64[0];
      if (!(m64.tvalid && m64.tlast)) misalign++;
    end
    if (mcf_valid64 !== stat64) stat_err++;
  end

  always @(negedge clk) begin
    if (m8.tvalid && m8.tready) begin
      if (m8.tkeep[0]) got8_q.push_back(m8.tdata);
      if (m8.tlast) gotu8_q.push_back(m8.tuser[0]);
    end
    if (mcf_valid8) begin
      pulse8++;
      cap_op8 = op8; cap_type8 = type8; cap_dst8 = dst8;
      if (!(m8.tvalid && m8.tlast)) misalign++;
    end
    if (mcf_valid8 !== stat8) stat_err++;
  end

  function automatic frame_t mk_frame(input logic [47:0] dst, input logic [15:0] ety,
                                      input logic [15:0] op, input int seed);
    frame_t f;
    logic [47:0] s;
    s = SRC;
    for (int i = 0; i < 128; i++) f[i] = 8'(i * 3 + seed);
    for (int k = 0; k < 6; k++) begin
      f[k]   = dst[47-8*k -: 8];
      f[6+k] = s[47-8*k -: 8];
    end
    f[12] = ety[15:8]; f[13] = ety[7:0];
    f[14] = op[15:8];  f[15] = op[7:0];
    f[16] = 8'hFF;     f[17] = 8'hFF;
    return f;
  endfunction

  function automatic logic [143:0] exp_params(input frame_t f, input int len);
    logic [143:0] p;
    p = '0;
    for (int j = 0; j < 18; j++) if (16 + j < len) p[8*j +: 8] = f[16+j];
    return p;
  endfunction

  // -1 when bytes and last-beat tuser match, -2 on length mismatch, else first bad index
  function automatic int stream_diff(input bit narrow);
    if (narrow) begin
      if (got8_q.size() != exp8_q.size() || gotu8_q.size() != expu8_q.size()) return -2;
      foreach (exp8_q[i]) if (got8_q[i] !== exp8_q[i]) return i;
      foreach (expu8_q[i]) if (gotu8_q[i] !== expu8_q[i]) return 1000 + i;
    end else begin
      if (got64_q.size() != exp64_q.size() || gotu64_q.size() != expu64_q.size()) return -2;
      foreach (exp64_q[i]) if (got64_q[i] !== exp64_q[i]) return i;
      foreach (expu64_q[i]) if (gotu64_q[i] !== expu64_q[i]) return 1000 + i;
    end
    return -1;
  endfunction

  task automatic clear_sb();
    exp64_q.delete(); got64_q.delete(); expu64_q.delete(); gotu64_q.delete();
    exp8_q.delete();  got8_q.delete();  expu8_q.delete();  gotu8_q.delete();
  endtask

  task automatic cfg_default();
    cfg_mcast = MCAST; cfg_ucast = UCAST; cfg_src = SRC;
    cfg_chk_mcast = 1'b1; cfg_chk_ucast = 1'b0; cfg_chk_src = 1'b0;
    cfg_type = 16'h8808; cfg_lfc = 16'h0001; cfg_chk_lfc = 1'b1;
    cfg_forward = 1'b0; cfg_enable = 1'b1;
  endtask

  // driver: called and returns at posedge+1; beats go back-to-back
  task automatic send_frame(input bit narrow, input frame_t f, input int len,
                            input bit uerr, input bit mark, input logic [7:0] id);
    int off, bw, n;
    bit acc, last;
    logic [63:0] d;
    logic [7:0] k;
    bw  = narrow ? 1 : 8;
    off = 0;
    while (off < len) begin
      d = '0; k = '0;
      for (int i = 0; i < bw; i++) begin
        if (off + i < len) begin
          d[8*i +: 8] = f[off+i];
          k[i] = 1'b1;
          if (narrow) exp8_q.push_back(f[off+i]); else exp64_q.push_back(f[off+i]);
        end
      end
      last = (off + bw >= len);
      if (narrow) begin
        s8.tvalid = 1'b1; s8.tdata = d[7:0]; s8.tkeep = k[0:0]; s8.tlast = last;
        s8.tuser = last && uerr; s8.tid = id; s8.tdest = ~id;
      end else begin
        s64.tvalid = 1'b1; s64.tdata = d; s64.tkeep = k; s64.tlast = last;
        s64.tuser = last && uerr; s64.tid = id; s64.tdest = ~id;
      end
      acc = 1'b0; n = 0;
      while (!acc && n < 500) begin
        @(negedge clk);
        acc = narrow ? s8.tready : s64.tready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout narrow=%0d offset=%0d got no tready, required accept", narrow, off);
        if (narrow) s8.tvalid = 1'b0; else s64.tvalid = 1'b0;
        return;
      end
      off += bw;
    end
    if (narrow) begin s8.tvalid = 1'b0; expu8_q.push_back(uerr | mark); end
    else begin s64.tvalid = 1'b0; expu64_q.push_back(uerr | mark); end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((got64_q.size() != exp64_q.size() || got8_q.size() != exp8_q.size()) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout got64=%0d exp64=%0d got8=%0d exp8=%0d",
               got64_q.size(), exp64_q.size(), got8_q.size(), exp8_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (m64.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m64.tvalid); end
    checks++; if (mcf_valid64 !== 1'b0) begin errors++; $display("FAIL reset_mcf_valid got %b want 0", mcf_valid64); end
    checks++; if (stat64 !== 1'b0) begin errors++; $display("FAIL reset_stat got %b want 0", stat64); end
    checks++; if (op64 !== 16'h0) begin errors++; $display("FAIL reset_opcode got %h want 0", op64); end
    checks++; if (par64 !== 144'h0) begin errors++; $display("FAIL reset_params got %h want 0", par64); end
    checks++; if (s64.tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s64.tready); end
    checks++; if (m8.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid8 got %b want 0", m8.tvalid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (s64.tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s64.tready); end
  endtask

  task automatic test_latency();
    s64.tvalid = 1'b1; s64.tdata = 64'h1122334455667788; s64.tkeep = 8'hFF;
    s64.tlast = 1'b1; s64.tuser = 1'b0; s64.tid = 8'h3C; s64.tdest = 8'hC3;
    @(posedge clk); #1;
    s64.tvalid = 1'b0;
    checks++; if (m64.tvalid !== 1'b1) begin errors++; $display("FAIL lat_tvalid got %b want 1", m64.tvalid); end
    checks++; if (m64.tdata !== 64'h1122334455667788) begin errors++; $display("FAIL lat_tdata got %h want 1122334455667788", m64.tdata); end
    checks++; if (m64.tkeep !== 8'hFF) begin errors++; $display("FAIL lat_tkeep got %h want ff", m64.tkeep); end
    checks++; if (m64.tlast !== 1'b1) begin errors++; $display("FAIL lat_tlast got %b want 1", m64.tlast); end
    checks++; if (m64.tid !== 8'h3C || m64.tdest !== 8'hC3) begin errors++; $display("FAIL lat_id got %h/%h want 3c/c3", m64.tid, m64.tdest); end
    checks++; if (mcf_valid64 !== 1'b0) begin errors++; $display("FAIL lat_short_pulse got %b want 0", mcf_valid64); end
    @(posedge clk); #1;
    checks++; if (m64.tvalid !== 1'b0) begin errors++; $display("FAIL lat_drain got %b want 0", m64.tvalid); end
    clear_sb();
  endtask

  task automatic test_mcf_drop();
    frame_t f;
    int p0, d;
    clear_sb(); cfg_default();
    p0 = pulse64;
    f  = mk_frame(MCAST, 16'h8808, 16'h0001, 5);
    send_frame(1'b0, f, 60, 1'b0, 1'b1, 8'h21);
    wait_drain();
    checks++; if (pulse64 - p0 != 1) begin errors++; $display("FAIL drop_pulses got %0d want 1", pulse64 - p0); end
    checks++; if (cap_op64 !== 16'h0001) begin errors++; $display("FAIL drop_opcode got %h want 0001", cap_op64); end
    checks++; if (cap_par64[15:0] !== 16'hFFFF) begin errors++; $display("FAIL drop_params_lo got %h want ffff", cap_par64[15:0]); end
    checks++; if (cap_par64 !== exp_params(f, 60)) begin errors++; $display("FAIL drop_params got %h want %h", cap_par64, exp_params(f, 60)); end
    checks++; if (cap_dst64 !== MCAST || cap_src64 !== SRC) begin errors++; $display("FAIL drop_addr got %h/%h want %h/%h", cap_dst64, cap_src64, MCAST, SRC); end
    checks++; if (cap_type64 !== 16'h8808) begin errors++; $display("FAIL drop_type got %h want 8808", cap_type64); end
    checks++; if (cap_id64 !== 8'h21 || cap_dest64 !== 8'hDE) begin errors++; $display("FAIL drop_id got %h/%h want 21/de", cap_id64, cap_dest64); end
    checks++; if (cap_user64 !== 1'b0) begin errors++; $display("FAIL drop_mcf_user got %b want 0", cap_user64); end
    checks++; if (gotu64_q.size() != 1 || gotu64_q[0] !== 1'b1) begin errors++; $display("FAIL drop_tuser got size %0d want one beat tuser 1", gotu64_q.size()); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL drop_stream diff at %0d want -1", d); end
    checks++; if (op64 !== 16'h0001) begin errors++; $display("FAIL drop_held_opcode got %h want 0001", op64); end
  endtask

  task automatic test_mcf_forward();
    frame_t f;
    int p0, d;
    clear_sb(); cfg_default(); cfg_forward = 1'b1;
    p0 = pulse64;
    f  = mk_frame(MCAST, 16'h8808, 16'h0001, 9);
    send_frame(1'b0, f, 60, 1'b0, 1'b0, 8'h22);
    wait_drain();
    checks++; if (pulse64 - p0 != 1) begin errors++; $display("FAIL fwd_pulses got %0d want 1", pulse64 - p0); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL fwd_stream diff at %0d want -1 (tuser 0)", d); end
    cfg_default();
  endtask

  task automatic test_non_mcf();
    frame_t f;
    int p0, d;
    clear_sb(); cfg_default();
    p0 = pulse64;
    f  = mk_frame(MCAST, 16'h0800, 16'h0001, 11);
    send_frame(1'b0, f, 64, 1'b0, 1'b0, 8'h5A);
    wait_drain();
    checks++; if (pulse64 - p0 != 0) begin errors++; $display("FAIL data_pulses got %0d want 0", pulse64 - p0); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL data_stream diff at %0d want -1", d); end
    checks++; if (last_id64 !== 8'h5A || last_dest64 !== 8'hA5) begin errors++; $display("FAIL data_id got %h/%h want 5a/a5", last_id64, last_dest64); end
  endtask

  task automatic test_user_err();
    frame_t f;
    int p0, d;
    clear_sb(); cfg_default();
    p0 = pulse64;
    f  = mk_frame(MCAST, 16'h8808, 16'h0001, 13);
    send_frame(1'b0, f, 60, 1'b1, 1'b0, 8'h07);
    wait_drain();
    checks++; if (pulse64 - p0 != 0) begin errors++; $display("FAIL uerr_pulses got %0d want 0", pulse64 - p0); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL uerr_stream diff at %0d want -1 (tuser 1)", d); end
  endtask

  task automatic test_filter();
    logic [47:0] t_dst [8] = '{MCAST, MCAST, MCAST, MCAST, MCAST, MCAST, UCAST, 48'hFFFFFFFFFFFF};
    logic [15:0] t_op  [8] = '{16'h0001, 16'h0101, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    int          t_len [8] = '{60, 60, 15, 16, 60, 60, 60, 60};
    bit          t_en  [8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    bit          t_mc  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit          t_uc  [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    bit          t_sc  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    bit          t_exp [8] = '{0, 0, 0, 1, 0, 0, 1, 1};
    frame_t f;
    int p0, d;
    for (int c = 0; c < 8; c++) begin
      clear_sb(); cfg_default();
      cfg_enable = t_en[c]; cfg_chk_mcast = t_mc[c]; cfg_chk_ucast = t_uc[c];
      cfg_chk_src = t_sc[c]; cfg_src = 48'h5A5152535499;
      p0 = pulse64;
      f  = mk_frame(t_dst[c], 16'h8808, t_op[c], 20 + c);
      send_frame(1'b0, f, t_len[c], 1'b0, t_exp[c], 8'(c));
      wait_drain();
      checks++; if (pulse64 - p0 != int'(t_exp[c])) begin errors++; $display("FAIL filter%0d_pulses got %0d want %0d", c, pulse64 - p0, t_exp[c]); end
      d = stream_diff(1'b0);
      checks++; if (d != -1) begin errors++; $display("FAIL filter%0d_stream diff at %0d want -1", c, d); end
      if (c == 3) begin
        checks++; if (cap_par64 !== 144'h0) begin errors++; $display("FAIL filter_short_params got %h want 0", cap_par64); end
        checks++; if (cap_op64 !== 16'h0001) begin errors++; $display("FAIL filter_short_opcode got %h want 0001", cap_op64); end
      end
    end
    cfg_default();
  endtask

  task automatic test_back_to_back();
    int p64, p8, mis0, st0, d;
    bit done64, done8;
    clear_sb(); cfg_default();
    p64 = pulse64; p8 = pulse8; mis0 = misalign; st0 = stat_err;
    done64 = 1'b0; done8 = 1'b0;
    fork
      begin
        frame_t fa;
        for (int k = 0; k < 10; k++) begin
          fa = mk_frame(MCAST, (k % 2 == 0) ? 16'h8808 : 16'h0800, 16'h0001, k);
          send_frame(1'b0, fa, 60 + 3 * k, 1'b0, (k % 2 == 0), 8'(k));
        end
        done64 = 1'b1;
      end
      begin
        frame_t fb;
        for (int k = 0; k < 10; k++) begin
          fb = mk_frame(MCAST, (k % 2 == 0) ? 16'h8808 : 16'h0800, 16'h0001, 40 + k);
          send_frame(1'b1, fb, 60 + 3 * k, 1'b0, (k % 2 == 0), 8'(k));
        end
        done8 = 1'b1;
      end
      begin
        while (!(done64 && done8)) begin
          m64.tready = 1'($urandom_range(0, 1));
          m8.tready  = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    m64.tready = 1'b1; m8.tready = 1'b1;
    wait_drain();
    checks++; if (pulse64 - p64 != 5) begin errors++; $display("FAIL b2b_pulses64 got %0d want 5", pulse64 - p64); end
    checks++; if (pulse8 - p8 != 5) begin errors++; $display("FAIL b2b_pulses8 got %0d want 5", pulse8 - p8); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_stream64 diff at %0d want -1", d); end
    d = stream_diff(1'b1);
    checks++; if (d != -1) begin errors++; $display("FAIL b2b_stream8 diff at %0d want -1", d); end
    checks++; if (misalign != mis0) begin errors++; $display("FAIL b2b_pulse_align got %0d misaligned want 0", misalign - mis0); end
    checks++; if (stat_err != st0) begin errors++; $display("FAIL b2b_stat got %0d mismatches want 0", stat_err - st0); end
    checks++; if (cap_op8 !== 16'h0001 || cap_type8 !== 16'h8808 || cap_dst8 !== MCAST || src8 !== SRC)
      begin errors++; $display("FAIL b2b_fields8 got %h/%h/%h want 0001/8808/%h", cap_op8, cap_type8, cap_dst8, MCAST); end
  endtask

  task automatic test_reset_mid_frame();
    frame_t f;
    int p0, d;
    clear_sb(); cfg_default();
    f = mk_frame(MCAST, 16'h8808, 16'h0001, 77);
    for (int b = 0; b < 2; b++) begin
      s64.tvalid = 1'b1; s64.tkeep = 8'hFF; s64.tlast = 1'b0; s64.tuser = 1'b0;
      for (int i = 0; i < 8; i++) s64.tdata[8*i +: 8] = f[8*b + i];
      @(posedge clk); #1;
    end
    s64.tvalid = 1'b0;
    checks++; if (m64.tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_tvalid got %b want 1", m64.tvalid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (m64.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m64.tvalid); end
    checks++; if (op64 !== 16'h0 || dst64 !== 48'h0) begin errors++; $display("FAIL rstmid_fields got %h/%h want 0/0", op64, dst64); end
    checks++; if (s64.tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready got %b want 0", s64.tready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    clear_sb();
    p0 = pulse64;
    f  = mk_frame(MCAST, 16'h8808, 16'h0001, 90);
    send_frame(1'b0, f, 60, 1'b0, 1'b1, 8'h44);
    wait_drain();
    checks++; if (pulse64 - p0 != 1) begin errors++; $display("FAIL rstmid_pulses got %0d want 1", pulse64 - p0); end
    checks++; if (cap_par64 !== exp_params(f, 60)) begin errors++; $display("FAIL rstmid_params got %h want %h", cap_par64, exp_params(f, 60)); end
    d = stream_diff(1'b0);
    checks++; if (d != -1) begin errors++; $display("FAIL rstmid_stream diff at %0d want -1", d); end
  endtask

  initial begin
    cfg_default();
    s64.tvalid = 1'b0; s64.tdata = '0; s64.tkeep = '0; s64.tlast = 1'b0; s64.tid = '0; s64.tdest = '0; s64.tuser = '0;
    s8.tvalid  = 1'b0; s8.tdata  = '0; s8.tkeep  = '0; s8.tlast  = 1'b0; s8.tid  = '0; s8.tdest  = '0; s8.tuser  = '0;
    m64.tready = 1'b1; m8.tready = 1'b1;
    test_reset();
    test_latency();
    test_mcf_drop();
    test_mcf_forward();
    test_non_mcf();
    test_user_err();
    test_filter();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_mac_ctrl_rx.md
Name: taxi_mac_ctrl_rx

Overview:
- Receive-side MAC control frame (MCF) extractor; sits between the MAC RX datapath and the user RX stream.
- Passes all frames through with one register stage.
- Parses the Ethernet header, opcode and parameter bytes of each frame. Frames that qualify as MAC control frames produce a one-cycle mcf_valid pulse carrying the extracted fields.
- Qualifying frames are either forwarded untouched or marked bad (tuser[0]=1 on tlast) so a downstream drop FIFO discards them.

Parameters:
- DATA_W, 64, stream data width in bits; supported values 8/16/32/64 (taken from the s_axis interface).
- ID_W, 8, tid width.
- DEST_W, 8, tdest width.
- USER_W, 1, tuser width; bit 0 is the bad-frame flag.
- MCF_PARAMS_SIZE, 18, bytes of parameter field captured after the opcode.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- s_axis  sink  taxi_axis_if (DATA_W, ID, DEST, USER enabled)  frames from MAC RX
- m_axis  source  taxi_axis_if (same params)  frames to user
- mcf_valid  output  1  one-cycle pulse: control frame received
- mcf_eth_dst  output  48  destination MAC (byte 0 = MSB)
- mcf_eth_src  output  48  source MAC
- mcf_eth_type  output  16  EtherType
- mcf_opcode  output  16  opcode
- mcf_params  output  MCF_PARAMS_SIZE*8  params; first param byte in bits [7:0]
- mcf_id  output  ID_W  tid of frame
- mcf_dest  output  DEST_W  tdest of frame
- mcf_user  output  USER_W  tuser of the last beat
- cfg_mcf_rx_eth_dst_mcast  input  48  accepted multicast dst (normally 01:80:C2:00:00:01)
- cfg_mcf_rx_check_eth_dst_mcast  input  1  enable multicast dst match
- cfg_mcf_rx_eth_dst_ucast  input  48  accepted unicast dst
- cfg_mcf_rx_check_eth_dst_ucast  input  1  enable unicast dst match
- cfg_mcf_rx_eth_src  input  48  required src
- cfg_mcf_rx_check_eth_src  input  1  enable src check
- cfg_mcf_rx_eth_type  input  16  required EtherType (normally 0x8808)
- cfg_mcf_rx_opcode_lfc  input  16  link-flow-control opcode (normally 0x0001)
- cfg_mcf_rx_check_opcode_lfc  input  1  accept LFC opcode
- cfg_mcf_rx_forward  input  1  1 = forward matched MCFs unmarked
- cfg_mcf_rx_enable  input  1  0 = block transparent, no MCF detection
- stat_rx_mcf  output  1  one-cycle pulse per detected MCF (same cycle as mcf_valid)

Behaviour:
- Reset (rst low, async): m_axis.tvalid=0, mcf_valid=0, stat_rx_mcf=0, all mcf_* fields 0, byte counter 0, frame flags cleared. s_axis.tready=0 while rst is low. Deassertion is synchronized by the instantiating level.
- Datapath:
  - One output register stage.
  - s_axis.tready = m_axis.tready | ~m_axis.tvalid.
  - Each accepted beat appears on m_axis the next cycle with tdata/tkeep/tlast/tid/tdest unchanged.
  - tuser is unchanged except as below.
- Parsing:
  - A byte offset counter advances by popcount(tkeep) per accepted beat and saturates at 16+MCF_PARAMS_SIZE.
  - Bytes 0-5 go to dst, 6-11 to src, 12-13 to type, 14-15 to opcode, 16..15+MCF_PARAMS_SIZE to params.
  - The counter clears after a tlast beat.
- Match is evaluated on the tlast beat, including bytes present in that same beat. MCF detected when all of the following hold:
  - cfg_mcf_rx_enable=1;
  - frame length >= 16 bytes;
  - type equals cfg_mcf_rx_eth_type;
  - dst check passes: (check_mcast & dst==mcast) | (check_ucast & dst==ucast), or pass if neither check is enabled;
  - src check passes if enabled;
  - opcode check passes: (check_opcode_lfc & opcode==lfc), or pass if no opcode check is enabled;
  - input tuser[0]=0 on the tlast beat.
- Frames shorter than 16+MCF_PARAMS_SIZE bytes: unreceived param bytes read as 0.
- On MCF detect:
  - mcf_valid and stat_rx_mcf pulse high for exactly one cycle, in the cycle the tlast beat first becomes valid on m_axis.
  - mcf_* fields are updated the same cycle and held until the next detect.
  - There is no ready; the consumer must sample on the pulse.
- Drop marking: if an MCF is detected and cfg_mcf_rx_forward=0, the output tlast beat has tuser[0]=1. Otherwise tuser passes through.
- Frames with type==cfg_mcf_rx_eth_type that fail the dst/src/opcode checks are forwarded unmarked, with no pulse.
- Config inputs are sampled on the tlast beat; changes mid-frame take effect for that frame's decision only.
- Back-to-back frames (tlast followed immediately by the next frame's first beat) are handled at full rate.
- m_axis.tvalid held with tready=0 keeps all outputs stable.

Optional Feature:
- Macro TAXI_MAC_CTRL_RX_PFC_EN.
- When defined:
  - adds ports cfg_mcf_rx_opcode_pfc (input, 16, normally 0x0101) and cfg_mcf_rx_check_opcode_pfc (input, 1);
  - the opcode check accepts LFC match OR PFC match; pass-all applies only when both checks are disabled.
- When undefined: the ports are absent and only the LFC opcode check exists.

Test Plan:
- 60-byte frame: dst 01:80:C2:00:00:01, type 0x8808, opcode 0x0001, params 0xFFFF,…; mcast check on, forward=0. Required: one mcf_valid pulse with opcode=0x0001, mcf_params[15:0]=0xFFFF; m_axis tlast beat has tuser[0]=1; data bytes unchanged.
- Same frame with forward=1. Required: pulse occurs, output tuser[0]=0.
- 64-byte frame with type 0x0800. Required: no pulse, stream bit-identical at 1-cycle latency.
- MCF with input tuser[0]=1 on tlast. Required: no pulse, tuser[0]=1 passed through.
- Random m_axis.tready throttling across 10 back-to-back MCF/data frames at DATA_W=8 and 64. Required: exactly 5 pulses, no beat loss or reorder.
- rst asserted mid-frame, then the next frame is a valid MCF. Required: outputs clear immediately on rst, and the following frame is detected correctly.
